// File: rtl/axicb_pkg.sv
// Shared helpers for the crossbar master buffering stage: parameter checks and
// derived FIFO/counter widths.
package axicb_pkg;

    function automatic bit is_pow2(input int value);
        return (value >= 1) && ((value & (value - 1)) == 0);
    endfunction

    function automatic int fifo_depth(input int num, input int size);
        return num * size;
    endfunction

    function automatic int cnt_width(input int num);
        return $clog2(num + 1);
    endfunction

    // One extra bit above the address acts as the wrap flag.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/axicb_scfifo.sv
// Single-clock first-word-fall-through FIFO with registered storage and
// wrap-bit pointers; ready/valid on both sides.
module axicb_scfifo
    import axicb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = addr_width(DEPTH);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    fill;
    logic [WIDTH-1:0] mem [1<<AW];
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Occupancy by pointer difference also covers DEPTH=1, where the
    // address bit and the wrap bit coincide.
    assign fill      = wr_ptr - rd_ptr;
    assign full      = (fill == PW'(DEPTH));
    assign empty     = (wr_ptr == rd_ptr);

    assign in_ready  = aresetn & ~full;
    assign out_valid = aresetn & ~empty;
    assign out_data  = mem[rd_ptr[AW-1:0]];

    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

endmodule

// File: rtl/axicb_mst_buff.sv
// Buffering stage between an external AXI master and the crossbar switch:
// five per-channel FIFOs plus outstanding-request limiting on AW and AR.
module axicb_mst_buff
    import axicb_pkg::*;
#(
    parameter int AWCH_W           = 8,
    parameter int WCH_W            = 8,
    parameter int BCH_W            = 8,
    parameter int ARCH_W           = 8,
    parameter int RCH_W            = 8,
    parameter int MST_OSTDREQ_NUM  = 4,
    parameter int MST_OSTDREQ_SIZE = 1
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,

    input  logic                                  i_awvalid,
    output logic                                  i_awready,
    input  logic [AWCH_W-1:0]                     i_awch,
    input  logic                                  i_wvalid,
    output logic                                  i_wready,
    input  logic                                  i_wlast,
    input  logic [WCH_W-1:0]                      i_wch,
    output logic                                  i_bvalid,
    input  logic                                  i_bready,
    output logic [BCH_W-1:0]                      i_bch,
    input  logic                                  i_arvalid,
    output logic                                  i_arready,
    input  logic [ARCH_W-1:0]                     i_arch,
    output logic                                  i_rvalid,
    input  logic                                  i_rready,
    output logic                                  i_rlast,
    output logic [RCH_W-1:0]                      i_rch,

    output logic                                  o_awvalid,
    input  logic                                  o_awready,
    output logic [AWCH_W-1:0]                     o_awch,
    output logic                                  o_wvalid,
    input  logic                                  o_wready,
    output logic                                  o_wlast,
    output logic [WCH_W-1:0]                      o_wch,
    input  logic                                  o_bvalid,
    output logic                                  o_bready,
    input  logic [BCH_W-1:0]                      o_bch,
    output logic                                  o_arvalid,
    input  logic                                  o_arready,
    output logic [ARCH_W-1:0]                     o_arch,
    input  logic                                  o_rvalid,
    output logic                                  o_rready,
    input  logic                                  o_rlast,
    input  logic [RCH_W-1:0]                      o_rch,

    output logic [cnt_width(MST_OSTDREQ_NUM)-1:0] o_wr_ostd,
    output logic [cnt_width(MST_OSTDREQ_NUM)-1:0] o_rd_ostd
);

    localparam int CW      = cnt_width(MST_OSTDREQ_NUM);
    localparam int REQ_D   = MST_OSTDREQ_NUM;
    localparam int DATA_D  = fifo_depth(MST_OSTDREQ_NUM, MST_OSTDREQ_SIZE);

    if (!is_pow2(MST_OSTDREQ_NUM)) begin : g_bad_num
        $error("MST_OSTDREQ_NUM must be a power of 2 and >= 1");
    end
    if (!is_pow2(MST_OSTDREQ_SIZE)) begin : g_bad_size
        $error("MST_OSTDREQ_SIZE must be a power of 2 and >= 1");
    end

    logic [CW-1:0] wr_ostd;
    logic [CW-1:0] rd_ostd;
    logic          wr_room;
    logic          rd_room;
    logic          aw_fifo_ready;
    logic          ar_fifo_ready;
    logic          wr_inc;
    logic          wr_dec;
    logic          rd_inc;
    logic          rd_dec;

    assign wr_room   = (wr_ostd < CW'(MST_OSTDREQ_NUM));
    assign rd_room   = (rd_ostd < CW'(MST_OSTDREQ_NUM));
    assign i_awready = aw_fifo_ready & wr_room;
    assign i_arready = ar_fifo_ready & rd_room;

    assign wr_inc    = i_awvalid & i_awready;
    assign wr_dec    = i_bvalid & i_bready;
    assign rd_inc    = i_arvalid & i_arready;
    assign rd_dec    = i_rvalid & i_rready & i_rlast;

    assign o_wr_ostd = wr_ostd;
    assign o_rd_ostd = rd_ostd;

    // A request is outstanding from address acceptance until its response
    // (B, or the last R beat) is handed back to the master.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ostd <= '0;
            rd_ostd <= '0;
        end else begin
            case ({wr_inc, wr_dec})
                2'b10:   wr_ostd <= wr_ostd + 1'b1;
                2'b01:   wr_ostd <= wr_ostd - 1'b1;
                default: wr_ostd <= wr_ostd;
            endcase
            case ({rd_inc, rd_dec})
                2'b10:   rd_ostd <= rd_ostd + 1'b1;
                2'b01:   rd_ostd <= rd_ostd - 1'b1;
                default: rd_ostd <= rd_ostd;
            endcase
        end
    end

    axicb_scfifo #(.WIDTH(AWCH_W), .DEPTH(REQ_D)) u_aw_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_valid  (i_awvalid & wr_room),
        .in_ready  (aw_fifo_ready),
        .in_data   (i_awch),
        .out_valid (o_awvalid),
        .out_ready (o_awready),
        .out_data  (o_awch)
    );

    axicb_scfifo #(.WIDTH(WCH_W + 1), .DEPTH(DATA_D)) u_w_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_valid  (i_wvalid),
        .in_ready  (i_wready),
        .in_data   ({i_wlast, i_wch}),
        .out_valid (o_wvalid),
        .out_ready (o_wready),
        .out_data  ({o_wlast, o_wch})
    );

    axicb_scfifo #(.WIDTH(BCH_W), .DEPTH(REQ_D)) u_b_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_valid  (o_bvalid),
        .in_ready  (o_bready),
        .in_data   (o_bch),
        .out_valid (i_bvalid),
        .out_ready (i_bready),
        .out_data  (i_bch)
    );

    axicb_scfifo #(.WIDTH(ARCH_W), .DEPTH(REQ_D)) u_ar_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_valid  (i_arvalid & rd_room),
        .in_ready  (ar_fifo_ready),
        .in_data   (i_arch),
        .out_valid (o_arvalid),
        .out_ready (o_arready),
        .out_data  (o_arch)
    );

    axicb_scfifo #(.WIDTH(RCH_W + 1), .DEPTH(DATA_D)) u_r_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_valid  (o_rvalid),
        .in_ready  (o_rready),
        .in_data   ({o_rlast, o_rch}),
        .out_valid (i_rvalid),
        .out_ready (i_rready),
        .out_data  ({i_rlast, i_rch})
    );

endmodule

// File: tb/tb_axicb_mst_buff.sv
// Directed and randomised checks of the master buffering stage, NUM=4, SIZE=1.
module tb_axicb_mst_buff;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic       i_awvalid, i_awready;
    logic [7:0] i_awch;
    logic       i_wvalid, i_wready, i_wlast;
    logic [7:0] i_wch;
    logic       i_bvalid, i_bready;
    logic [7:0] i_bch;
    logic       i_arvalid, i_arready;
    logic [7:0] i_arch;
    logic       i_rvalid, i_rready, i_rlast;
    logic [7:0] i_rch;
    logic       o_awvalid, o_awready;
    logic [7:0] o_awch;
    logic       o_wvalid, o_wready, o_wlast;
    logic [7:0] o_wch;
    logic       o_bvalid, o_bready;
    logic [7:0] o_bch;
    logic       o_arvalid, o_arready;
    logic [7:0] o_arch;
    logic       o_rvalid, o_rready, o_rlast;
    logic [7:0] o_rch;
    logic [2:0] o_wr_ostd, o_rd_ostd;

    int errors = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    axicb_mst_buff #(
        .AWCH_W(8), .WCH_W(8), .BCH_W(8), .ARCH_W(8), .RCH_W(8),
        .MST_OSTDREQ_NUM(4), .MST_OSTDREQ_SIZE(1)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .i_awvalid(i_awvalid), .i_awready(i_awready), .i_awch(i_awch),
        .i_wvalid(i_wvalid), .i_wready(i_wready), .i_wlast(i_wlast), .i_wch(i_wch),
        .i_bvalid(i_bvalid), .i_bready(i_bready), .i_bch(i_bch),
        .i_arvalid(i_arvalid), .i_arready(i_arready), .i_arch(i_arch),
        .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rlast(i_rlast), .i_rch(i_rch),
        .o_awvalid(o_awvalid), .o_awready(o_awready), .o_awch(o_awch),
        .o_wvalid(o_wvalid), .o_wready(o_wready), .o_wlast(o_wlast), .o_wch(o_wch),
        .o_bvalid(o_bvalid), .o_bready(o_bready), .o_bch(o_bch),
        .o_arvalid(o_arvalid), .o_arready(o_arready), .o_arch(o_arch),
        .o_rvalid(o_rvalid), .o_rready(o_rready), .o_rlast(o_rlast), .o_rch(o_rch),
        .o_wr_ostd(o_wr_ostd), .o_rd_ostd(o_rd_ostd)
    );

    // Inputs change 1 ns after a rising edge; outputs are read 1 ns later.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs();
        i_awvalid = 0; i_awch = 0; i_wvalid = 0; i_wlast = 0; i_wch = 0;
        i_bready = 0; i_arvalid = 0; i_arch = 0; i_rready = 0;
        o_awready = 0; o_wready = 0; o_bvalid = 0; o_bch = 0;
        o_arready = 0; o_rvalid = 0; o_rlast = 0; o_rch = 0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        aresetn = 0;
        step();
        step();
        aresetn = 1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        aresetn = 0;
        step();
        checks++;
        if ({i_awready, i_wready, i_arready, o_bready, o_rready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_readies got=%b exp=00000",
                     {i_awready, i_wready, i_arready, o_bready, o_rready});
        end
        checks++;
        if ({o_awvalid, o_wvalid, o_arvalid, i_bvalid, i_rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_valids got=%b exp=00000",
                     {o_awvalid, o_wvalid, o_arvalid, i_bvalid, i_rvalid});
        end
        aresetn = 1;
        #1;
        checks++;
        if (o_wr_ostd !== 3'd0 || o_rd_ostd !== 3'd0) begin
            errors++;
            $display("FAIL reset_ostd got=%0d/%0d exp=0/0", o_wr_ostd, o_rd_ostd);
        end
        checks++;
        if (i_awready !== 1'b1 || i_wready !== 1'b1 || i_arready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready got=%b%b%b exp=111", i_awready, i_wready, i_arready);
        end
    endtask

    task automatic test_single_write();
        apply_reset();
        i_awvalid = 1; i_awch = 8'h12;
        i_wvalid = 1; i_wch = 8'hA5; i_wlast = 1;
        step();
        i_awvalid = 0; i_wvalid = 0; i_wlast = 0;
        #1;
        checks++;
        if (o_awvalid !== 1'b1 || o_awch !== 8'h12) begin
            errors++;
            $display("FAIL sw_aw got=%b/%h exp=1/12", o_awvalid, o_awch);
        end
        checks++;
        if (o_wvalid !== 1'b1 || o_wch !== 8'hA5 || o_wlast !== 1'b1) begin
            errors++;
            $display("FAIL sw_w got=%b/%h/%b exp=1/a5/1", o_wvalid, o_wch, o_wlast);
        end
        checks++;
        if (o_wr_ostd !== 3'd1) begin
            errors++;
            $display("FAIL sw_ostd_inc got=%0d exp=1", o_wr_ostd);
        end
        o_awready = 1; o_wready = 1;
        step();
        o_awready = 0; o_wready = 0;
        #1;
        checks++;
        if (o_awvalid !== 1'b0 || o_wvalid !== 1'b0) begin
            errors++;
            $display("FAIL sw_drain got=%b%b exp=00", o_awvalid, o_wvalid);
        end
        o_bvalid = 1; o_bch = 8'h03;
        step();
        o_bvalid = 0;
        #1;
        checks++;
        if (i_bvalid !== 1'b1 || i_bch !== 8'h03 || o_wr_ostd !== 3'd1) begin
            errors++;
            $display("FAIL sw_b got=%b/%h/%0d exp=1/03/1", i_bvalid, i_bch, o_wr_ostd);
        end
        i_bready = 1;
        step();
        i_bready = 0;
        #1;
        checks++;
        if (i_bvalid !== 1'b0 || o_wr_ostd !== 3'd0) begin
            errors++;
            $display("FAIL sw_ostd_dec got=%b/%0d exp=0/0", i_bvalid, o_wr_ostd);
        end
    endtask

    task automatic test_ostd_limit();
        int acc;
        apply_reset();
        acc = 0;
        i_arvalid = 1;
        for (int c = 0; c < 5; c++) begin
            i_arch = 8'(acc);
            #1;
            if (i_arready) acc++;
            step();
        end
        i_arch = 8'(acc);
        #1;
        checks++;
        if (acc != 4 || i_arready !== 1'b0 || o_rd_ostd !== 3'd4) begin
            errors++;
            $display("FAIL ostd_limit acc=%0d rdy=%b ostd=%0d exp=4/0/4", acc, i_arready, o_rd_ostd);
        end
        o_arready = 1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (o_arvalid !== 1'b1 || o_arch !== 8'(k)) begin
                errors++;
                $display("FAIL ostd_ar_order k=%0d got=%b/%h exp=1/%h", k, o_arvalid, o_arch, 8'(k));
            end
            step();
        end
        o_arready = 0;
        #1;
        checks++;
        if (i_arready !== 1'b0) begin
            errors++;
            $display("FAIL ostd_still_blocked got=%b exp=0", i_arready);
        end
        o_rvalid = 1; o_rlast = 1; o_rch = 8'h5A;
        step();
        o_rvalid = 0; o_rlast = 0;
        i_rready = 1;
        #1;
        checks++;
        if (i_rvalid !== 1'b1 || i_rlast !== 1'b1 || i_rch !== 8'h5A || i_arready !== 1'b0) begin
            errors++;
            $display("FAIL ostd_r got=%b/%b/%h rdy=%b exp=1/1/5a rdy=0", i_rvalid, i_rlast, i_rch, i_arready);
        end
        step();
        i_rready = 0;
        #1;
        checks++;
        if (i_arready !== 1'b1 || o_rd_ostd !== 3'd3) begin
            errors++;
            $display("FAIL ostd_freed rdy=%b ostd=%0d exp=1/3", i_arready, o_rd_ostd);
        end
        step();
        i_arvalid = 0;
        #1;
        checks++;
        if (o_rd_ostd !== 3'd4 || o_arvalid !== 1'b1 || o_arch !== 8'h04) begin
            errors++;
            $display("FAIL ostd_fifth ostd=%0d ar=%b/%h exp=4/1/04", o_rd_ostd, o_arvalid, o_arch);
        end
    endtask

    task automatic test_backpressure();
        int sent, rcv, acc_cnt;
        logic [7:0] exp_d;
        logic       exp_l;
        apply_reset();
        sent = 0; acc_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            i_wvalid = 1; i_wch = 8'(8'h10 + sent); i_wlast = sent[0];
            #1;
            if (i_wready) acc_cnt++;
            step();
            if (acc_cnt > sent) sent = acc_cnt;
        end
        i_wvalid = 1; i_wch = 8'(8'h10 + sent); i_wlast = sent[0];
        #1;
        checks++;
        if (sent != 4 || i_wready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full sent=%0d rdy=%b exp=4/0", sent, i_wready);
        end
        rcv = 0;
        o_wready = 1;
        for (int c = 0; c < 40 && rcv < 8; c++) begin
            logic accepted;
            i_wvalid = (sent < 8); i_wch = 8'(8'h10 + sent); i_wlast = sent[0];
            #1;
            accepted = i_wvalid & i_wready;
            if (o_wvalid) begin
                exp_d = 8'(8'h10 + rcv);
                exp_l = rcv[0];
                checks++;
                if (o_wch !== exp_d || o_wlast !== exp_l) begin
                    errors++;
                    $display("FAIL bp_order beat=%0d got=%h/%b exp=%h/%b", rcv, o_wch, o_wlast, exp_d, exp_l);
                end
                rcv++;
            end
            step();
            if (accepted) sent++;
        end
        i_wvalid = 0; o_wready = 0;
        checks++;
        if (rcv != 8) begin
            errors++;
            $display("FAIL bp_count got=%0d exp=8", rcv);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        i_awvalid = 1; i_awch = 8'h21;
        step();
        i_awch = 8'h22;
        step();
        i_awvalid = 0;
        o_bvalid = 1; o_bch = 8'h01;
        step();
        o_bvalid = 0;
        #1;
        checks++;
        if (o_wr_ostd !== 3'd2 || i_bvalid !== 1'b1) begin
            errors++;
            $display("FAIL sim_setup ostd=%0d b=%b exp=2/1", o_wr_ostd, i_bvalid);
        end
        i_awvalid = 1; i_awch = 8'h23; i_bready = 1;
        #1;
        checks++;
        if (i_awready !== 1'b1) begin
            errors++;
            $display("FAIL sim_awready got=%b exp=1", i_awready);
        end
        step();
        i_awvalid = 0; i_bready = 0;
        #1;
        checks++;
        if (o_wr_ostd !== 3'd2) begin
            errors++;
            $display("FAIL sim_ostd got=%0d exp=2", o_wr_ostd);
        end
        for (int k = 0; k < 4; k++) begin
            i_wvalid = 1; i_wch = 8'(8'h30 + k); i_wlast = 1;
            step();
        end
        i_wch = 8'h34; o_wready = 1;
        #1;
        checks++;
        if (i_wready !== 1'b0 || o_wch !== 8'h30) begin
            errors++;
            $display("FAIL sim_full_pushpop rdy=%b out=%h exp=0/30", i_wready, o_wch);
        end
        for (int k = 1; k < 5; k++) begin
            step();
            i_wvalid = (k == 1);
            #1;
            checks++;
            if (o_wvalid !== 1'b1 || o_wch !== 8'(8'h30 + k)) begin
                errors++;
                $display("FAIL sim_order k=%0d got=%b/%h exp=1/%h", k, o_wvalid, o_wch, 8'(8'h30 + k));
            end
        end
        i_wvalid = 0; o_wready = 0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            i_wvalid = 1; i_wch = 8'(8'h40 + k); i_wlast = 0;
            step();
        end
        i_wvalid = 0;
        i_arvalid = 1; i_arch = 8'h55;
        step();
        i_arvalid = 0;
        aresetn = 0;
        #1;
        checks++;
        if (i_wready !== 1'b0 || i_awready !== 1'b0 || o_wvalid !== 1'b0) begin
            errors++;
            $display("FAIL rm_during rdy=%b%b wv=%b exp=00/0", i_wready, i_awready, o_wvalid);
        end
        step();
        aresetn = 1;
        #1;
        checks++;
        if (o_wvalid !== 1'b0 || o_arvalid !== 1'b0 || o_rd_ostd !== 3'd0 || o_wr_ostd !== 3'd0) begin
            errors++;
            $display("FAIL rm_after wv=%b arv=%b ostd=%0d/%0d exp=0/0/0/0",
                     o_wvalid, o_arvalid, o_wr_ostd, o_rd_ostd);
        end
        i_wvalid = 1; i_wch = 8'h77; i_wlast = 1;
        step();
        i_wvalid = 0; o_wready = 1;
        #1;
        checks++;
        if (o_wvalid !== 1'b1 || o_wch !== 8'h77 || o_wlast !== 1'b1) begin
            errors++;
            $display("FAIL rm_first got=%b/%h/%b exp=1/77/1", o_wvalid, o_wch, o_wlast);
        end
        step();
        o_wready = 0;
        #1;
        checks++;
        if (o_wvalid !== 1'b0) begin
            errors++;
            $display("FAIL rm_alone got=%b exp=0", o_wvalid);
        end
    endtask

    task automatic test_random();
        logic [8:0] w_q[$];
        logic [7:0] b_q[$];
        logic [8:0] w_exp;
        logic [7:0] b_exp;
        int         model_wr;
        int         pend;
        logic [7:0] w_seq;
        logic       aw_hs, b_hs, ob_hs, oaw_hs, w_hs;
        apply_reset();
        model_wr = 0; pend = 0; w_seq = 0;
        for (int c = 0; c < 3000; c++) begin
            i_awvalid = 1'($urandom); i_awch = 8'($urandom);
            o_awready = 1'($urandom);
            i_bready  = 1'($urandom);
            o_bvalid  = (pend > 0) ? 1'($urandom) : 1'b0;
            o_bch     = 8'($urandom);
            i_wvalid  = 1'($urandom); i_wch = w_seq; i_wlast = w_seq[1];
            o_wready  = 1'($urandom);
            #1;
            checks++;
            if (int'(o_wr_ostd) != model_wr || o_wr_ostd > 3'd4) begin
                errors++;
                $display("FAIL rnd_ostd cyc=%0d got=%0d exp=%0d", c, o_wr_ostd, model_wr);
            end
            aw_hs  = i_awvalid & i_awready;
            b_hs   = i_bvalid & i_bready;
            oaw_hs = o_awvalid & o_awready;
            ob_hs  = o_bvalid & o_bready;
            w_hs   = i_wvalid & i_wready;
            if (w_hs) w_q.push_back({i_wlast, i_wch});
            if (ob_hs) b_q.push_back(o_bch);
            if (o_wvalid & o_wready) begin
                w_exp = (w_q.size() > 0) ? w_q.pop_front() : 9'h1FF;
                checks++;
                if ({o_wlast, o_wch} !== w_exp) begin
                    errors++;
                    $display("FAIL rnd_w cyc=%0d got=%h exp=%h", c, {o_wlast, o_wch}, w_exp);
                end
            end
            if (b_hs) begin
                b_exp = (b_q.size() > 0) ? b_q.pop_front() : 8'hxx;
                checks++;
                if (i_bch !== b_exp) begin
                    errors++;
                    $display("FAIL rnd_b cyc=%0d got=%h exp=%h", c, i_bch, b_exp);
                end
            end
            step();
            if (aw_hs) model_wr++;
            if (b_hs)  model_wr--;
            if (oaw_hs) pend++;
            if (ob_hs)  pend--;
            if (w_hs)   w_seq++;
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        aresetn = 0;
        test_reset();
        test_single_write();
        test_ostd_limit();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
